sar_adc_ctrl: RTL

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/sar_adc_ctrl.sv
//------------------------------------------------------------------------------
// sar_adc_ctrl : successive-approximation ADC controller (sample, MSB-first search)
// Optional build macro SARADC_CONT_EN enables back-to-back conversions via cont.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sar_adc_ctrl #(
   parameter int WIDTH         = 5,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             cont,
   input  logic             cmp,
   output logic [WIDTH-1:0] dac_code,
   output logic             sample,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   output logic             busy
);

   // One down-counter serves both the sample phase and the bit index.
   localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam int CNT_W = (SMP_W > BIT_W) ? SMP_W : BIT_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   code_q,  code_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   w_bit;
   logic               w_start;

   assign w_bit = {{(WIDTH-1){1'b0}}, 1'b1} << cnt_q;

`ifndef SARADC_CONT_EN
   logic w_unused_cont;
   assign w_unused_cont = cont;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      result_d = result_q;
      w_start  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) w_start = 1'b1;
         end
         ST_SAMPLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CONVERT;
               cnt_d   = CNT_W'(WIDTH - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CONVERT: begin
            // Bit under test is already 0 in code_q, so only a keep needs a write.
            if (cmp) code_d = code_q | w_bit;
            if (cnt_q == '0) begin
               state_d  = ST_DONE;
               result_d = cmp ? (code_q | w_bit) : code_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef SARADC_CONT_EN
            if (cont) w_start = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_start) begin
         state_d = ST_SAMPLE;
         cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
         code_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         code_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         result_q <= result_d;
      end
   end

   assign dac_code = (state_q == ST_CONVERT) ? (code_q | w_bit) : '0;
   assign sample   = (state_q == ST_SAMPLE);
   assign valid    = (state_q == ST_DONE);
   assign busy     = (state_q != ST_IDLE);
   assign result   = result_q;

endmodule

`default_nettype wire
